// File: rtl/add_ctrl_pkg.sv
// Shared types for the nibble-serial add controller: FSM state encoding and
// the nibble-counter width helper.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for NIB passes; never narrower than one bit.
  function automatic int nib_cnt_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple-carry adder with carry-in, built from gate-level full-adder cells.
// This is the only arithmetic in the serial add controller.
module nibble_adder_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic p0, p1, p2, p3;
  logic c1, c2, c3;

  assign p0     = a[0] ^ b[0];
  assign sum[0] = p0 ^ cin;
  assign c1     = (a[0] & b[0]) | (p0 & cin);

  assign p1     = a[1] ^ b[1];
  assign sum[1] = p1 ^ c1;
  assign c2     = (a[1] & b[1]) | (p1 & c1);

  assign p2     = a[2] ^ b[2];
  assign sum[2] = p2 ^ c2;
  assign c3     = (a[2] & b[2]) | (p2 & c2);

  assign p3     = a[3] ^ b[3];
  assign sum[3] = p3 ^ c3;
  assign cout   = (a[3] & b[3]) | (p3 & c3);

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit adder.
// Define ADD_CTRL_SUB_EN to honour op_sub (A-B via inverted B and carry-in 1).
module nibble_serial_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int NIB       = WIDTH / 4;
  localparam int NIB_CNT_W = nib_cnt_w(NIB);
  localparam logic [NIB_CNT_W-1:0] LAST_CNT = NIB_CNT_W'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t               state;
  logic [NIB_CNT_W-1:0] cnt;
  logic                 carry;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH:0]       sum_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic [3:0]           a_nib;
  logic [3:0]           b_nib;
  logic [3:0]           nib_sum;
  logic                 nib_cout;
  logic                 init_carry;
  logic [WIDTH-1:0]     sum_upd;

  // Operands shift down a nibble per pass, so the adder always sees bits [3:0].
  assign a_nib = a_q[3:0];

`ifdef ADD_CTRL_SUB_EN
  logic sub_q;
  assign b_nib      = sub_q ? ~b_q[3:0] : b_q[3:0];
  assign init_carry = op_sub;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_nib         = b_q[3:0];
  assign init_carry    = 1'b0;
`endif

  nibble_adder_cin u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Only the nibble selected by cnt takes the new sum; the rest hold.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_sum_upd
    assign sum_upd[4*gi +: 4] = (cnt == NIB_CNT_W'(gi)) ? nib_sum : sum_q[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ADD_CTRL_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= op_a;
            b_q        <= op_b;
            cnt        <= '0;
            carry      <= init_carry;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= CALC;
`ifdef ADD_CTRL_SUB_EN
            sub_q      <= op_sub;
`endif
          end
        end
        CALC: begin
          sum_q[WIDTH-1:0] <= sum_upd;
          a_q              <= a_q >> 4;
          b_q              <= b_q >> 4;
          carry            <= nib_cout;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            sum_q[WIDTH] <= nib_cout;
            cnt          <= '0;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (WIDTH=16); honours ADD_CTRL_SUB_EN
// in its reference model when that macro is defined.
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;
`ifdef ADD_CTRL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         busy;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] sum;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   last_acc = -1;
  bit   b2b     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: unsigned sum with carry, or difference with the no-borrow flag.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W-1:0] diff;
    if (SUB_EN && sub) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic [W:0] want);
    int waited = 0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = sub;
    while (!in_ready) begin
      tick();
      waited++;
      if (waited > 200) begin
        fail_now("in_ready_wait");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back('{sum: want, acc: cyc + 1});
    if (b2b && last_acc >= 0) check("throughput", 64'(cyc + 1 - last_acc), 64'(NIB + 2));
    last_acc = cyc + 1;
    tick();
    in_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    op_sub = 1'($urandom);
  endtask

  // Monitor: latency on rise, stability while stalled, value on handshake.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [W:0] prev_sum   = '0;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %0h expected none", out_sum);
        end else begin
          check("latency", 64'(cyc), 64'(exp_q[0].acc + NIB));
        end
      end
      if (out_valid && prev_valid && !prev_ready)
        check("hold_sum", 64'(out_sum), 64'(prev_sum));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("txn acc=%0d sum=%h expected=%h", e.acc, out_sum, e.sum);
        check("result", 64'(out_sum), 64'(e.sum));
      end
      prev_valid <= out_valid;
      prev_ready <= out_ready;
      prev_sum   <= out_sum;
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           waited;

    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    op_sub = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // Directed sums.
    send(16'h00FF, 16'h0001, 1'b0, 17'h00100);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    send(16'h0000, 16'h0000, 1'b0, 17'h00000);
`ifdef ADD_CTRL_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 17'h0FFFE);
    send(16'h0007, 16'h0005, 1'b1, 17'h10002);
`else
    send(16'h0005, 16'h0007, 1'b1, 17'h0000C);
    send(16'h0007, 16'h0005, 1'b1, 17'h0000C);
`endif

    // Consumer stall: output held, input side blocked, stray in_valid ignored.
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      tick();
      waited++;
    end
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 17'h05555);
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!out_valid) fail_now("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(in_ready), 64'(0));
      in_valid = (i % 2 == 0);
      op_a = W'($urandom);
      op_b = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_hs_in_ready", 64'(in_ready), 64'(1));
    check("post_hs_out_valid", 64'(out_valid), 64'(0));

    // Reset mid-operation at nibble pass 2.
    send(16'hABCD, 16'h1111, 1'b0, 17'h0BCDE);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_out_sum", 64'(out_sum), 64'(0));
    exp_q.delete();
    last_acc = -1;
    tick();
    rst_n = 1'b1;
    tick();
    send(16'h8000, 16'h8000, 1'b0, 17'h10000);

    // Random back-to-back traffic against the reference model.
    b2b = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rs, model(ra, rb, rs));
    end
    b2b = 1'b0;

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      tick();
      waited++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
